jamma_joy_mux: RTL and testbench

Parametrised, time-multiplexed JAMMA controls scanner. It drives a player-select line onto the shared JAMMA joystick bus and waits a programmable settling time after each select change. It then samples the bus, debounces each player's sample and publishes a stable, active-low control vector per player to the arcade core. It replaces the fixed 2-player toggle-every-clock capture in each arcade top and adds player count, settle time, debounce and a local (keyboard/DB9) overlay.

---
 rtl/jamma_joy_mux.sv | 134 +++++++++++++
 tb/tb_jamma_joy_mux.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jamma_joy_mux.sv
// jamma_joy_mux
//
// Time-multiplexed JAMMA controls scanner. A player-select index is driven
// onto the shared joystick bus. Each select value is held for SETTLE enabled
// cycles, and the bus is sampled on the last of them. Each player's sample is
// debounced as a whole slice and then published as a stable, active-low
// control vector. The local overlay (keyboard/DB9) is ANDed into player 0 only.
//
// Ports:
//   I_CLK      - clock, rising edge
//   I_RESET_N  - asynchronous active-low reset
//   I_ENA      - clock enable; all state holds while low
//   I_JOY      - shared JAMMA bus, active-low, WIDTH bits
//   I_LOCAL    - local overlay, active-low, applied to player 0
//   O_SELECT   - index of the player currently selected on the bus
//   O_JOY      - debounced controls; player p at [p*WIDTH +: WIDTH]
//   O_CHANGED  - one-cycle pulse when any player's slice changes
//   O_FRAME    - one-cycle pulse after the sample that wraps O_SELECT to 0

module jamma_joy_mux #(
   parameter int  PLAYERS  = 2,
   parameter int  WIDTH    = 8,
   parameter int  SETTLE   = 1,
   parameter int  DEBOUNCE = 1,
   localparam int SEL_W    = (PLAYERS <= 2) ? 1 : $clog2(PLAYERS)
) (
   input  logic                       I_CLK,
   input  logic                       I_RESET_N,
   input  logic                       I_ENA,
   input  logic [WIDTH-1:0]           I_JOY,
   input  logic [WIDTH-1:0]           I_LOCAL,
   output logic [SEL_W-1:0]           O_SELECT,
   output logic [PLAYERS*WIDTH-1:0]   O_JOY,
   output logic                       O_CHANGED,
   output logic                       O_FRAME
);

   localparam int CNT_W = (SETTLE <= 1) ? 1 : $clog2(SETTLE);
   localparam int AGW   = $clog2(DEBOUNCE + 1);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
   localparam logic [AGW-1:0]   AG_MAX   = AGW'(DEBOUNCE);
   localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(PLAYERS - 1);

   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] cand      [PLAYERS];
   logic [AGW-1:0]   agree     [PLAYERS];
   logic [WIDTH-1:0] cand_nxt  [PLAYERS];
   logic [AGW-1:0]   agree_nxt [PLAYERS];
   logic [PLAYERS-1:0] commit;

   logic             sample;
   logic             last_sel;
   logic [WIDTH-1:0] s;
   logic             changed_nxt;

   // The sample is taken on the last enabled cycle of the slot.
   assign sample   = I_ENA && (cnt == '0);
   assign last_sel = (O_SELECT == SEL_LAST);

   // Overlay applies to player 0 only.
   always_comb begin
      s = I_JOY;
      if (O_SELECT == '0)
         s = I_JOY & I_LOCAL;
   end

   // Whole-slice debounce: any differing bit restarts the agreement count.
   always_comb begin
      commit = '0;
      for (int p = 0; p < PLAYERS; p++) begin
         cand_nxt[p]  = cand[p];
         agree_nxt[p] = agree[p];
         if (sample && (O_SELECT == SEL_W'(p))) begin
            if (s != cand[p]) begin
               cand_nxt[p]  = s;
               agree_nxt[p] = AGW'(1);
            end else if (agree[p] != AG_MAX) begin
               agree_nxt[p] = agree[p] + AGW'(1);
            end
            commit[p] = (agree_nxt[p] == AG_MAX);
         end
      end
   end

   always_comb begin
      changed_nxt = 1'b0;
      for (int p = 0; p < PLAYERS; p++) begin
         if (commit[p] && (O_JOY[p*WIDTH +: WIDTH] != s))
            changed_nxt = 1'b1;
      end
   end

   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         cnt       <= CNT_LOAD;
         O_SELECT  <= '0;
         O_JOY     <= '1;
         O_CHANGED <= 1'b0;
         O_FRAME   <= 1'b0;
         for (int p = 0; p < PLAYERS; p++) begin
            cand[p]  <= '1;
            agree[p] <= '0;
         end
      end else begin
         // Pulses are recomputed every cycle so they can never stretch,
         // including while I_ENA is low.
         O_CHANGED <= changed_nxt;
         O_FRAME   <= sample && last_sel;

         if (I_ENA) begin
            if (cnt == '0)
               cnt <= CNT_LOAD;
            else
               cnt <= cnt - CNT_W'(1);
         end

         if (sample) begin
            if (last_sel)
               O_SELECT <= '0;
            else
               O_SELECT <= O_SELECT + SEL_W'(1);
         end

         for (int p = 0; p < PLAYERS; p++) begin
            cand[p]  <= cand_nxt[p];
            agree[p] <= agree_nxt[p];
            if (commit[p])
               O_JOY[p*WIDTH +: WIDTH] <= s;
         end
      end
   end

endmodule

// File: tb/tb_jamma_joy_mux.sv
module tb_jamma_joy_mux;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   // Instance A: 2 players, legacy timing. Instance B: 3 players, slow scan.
   logic        ena_a = 1'b0, ena_b = 1'b0;
   logic [7:0]  joy_a = 8'hFF, joy_b = 8'hFF;
   logic [7:0]  local_a = 8'hFF, local_b = 8'hFF;
   logic [0:0]  sel_a;
   logic [1:0]  sel_b;
   logic [15:0] ojoy_a;
   logic [23:0] ojoy_b;
   logic        chg_a, chg_b, frm_a, frm_b;

   jamma_joy_mux #(.PLAYERS(2), .WIDTH(8), .SETTLE(1), .DEBOUNCE(1)) dut_a (
      .I_CLK(clk), .I_RESET_N(rst_n), .I_ENA(ena_a), .I_JOY(joy_a),
      .I_LOCAL(local_a), .O_SELECT(sel_a), .O_JOY(ojoy_a),
      .O_CHANGED(chg_a), .O_FRAME(frm_a));

   jamma_joy_mux #(.PLAYERS(3), .WIDTH(8), .SETTLE(4), .DEBOUNCE(3)) dut_b (
      .I_CLK(clk), .I_RESET_N(rst_n), .I_ENA(ena_b), .I_JOY(joy_b),
      .I_LOCAL(local_b), .O_SELECT(sel_b), .O_JOY(ojoy_b),
      .O_CHANGED(chg_b), .O_FRAME(frm_b));

   // ---------------- scoreboard counters ----------------
   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Position in the scan is an enabled-cycle count; a player's committed
   // value is the latest sample once it has repeated DEBOUNCE times in a row.
   int         pl [2] = '{2, 3};
   int         st [2] = '{1, 4};
   int         db [2] = '{1, 3};
   int         n_en [2];
   int         run_len [2][4];
   logic [7:0] last_s [2][4];
   logic [7:0] mj [2][4];
   logic       mchg [2];
   logic       mfrm [2];

   function automatic int m_sel(input int i);
      return (n_en[i] / st[i]) % pl[i];
   endfunction

   function automatic logic [31:0] exp_joy(input int i);
      logic [31:0] v = '0;
      for (int p = 0; p < pl[i]; p++) v[p*8 +: 8] = mj[i][p];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         n_en[i] = 0; mchg[i] = 1'b0; mfrm[i] = 1'b0;
         for (int p = 0; p < 4; p++) begin
            run_len[i][p] = 0; last_s[i][p] = 8'hFF; mj[i][p] = 8'hFF;
         end
      end
   endtask

   task automatic model_step(input int i, input logic en, input logic [7:0] j,
                             input logic [7:0] l);
      int p;
      logic [7:0] smp;
      mchg[i] = 1'b0;
      mfrm[i] = 1'b0;
      if (en) begin
         p = m_sel(i);
         if (n_en[i] % st[i] == st[i] - 1) begin
            smp = (p == 0) ? (j & l) : j;
            if (smp == last_s[i][p]) run_len[i][p]++;
            else begin last_s[i][p] = smp; run_len[i][p] = 1; end
            if (run_len[i][p] >= db[i]) begin
               if (mj[i][p] != smp) mchg[i] = 1'b1;
               mj[i][p] = smp;
            end
            if (p == pl[i] - 1) mfrm[i] = 1'b1;
         end
         n_en[i] = (n_en[i] + 1) % (pl[i] * st[i]);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else begin
         model_step(0, ena_a, joy_a, local_a);
         model_step(1, ena_b, joy_b, local_b);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("sel_a", 32'(sel_a), 32'(m_sel(0)));
         chk("joy_a", 32'(ojoy_a), exp_joy(0));
         chk("chg_a", 32'(chg_a), 32'(mchg[0]));
         chk("frm_a", 32'(frm_a), 32'(mfrm[0]));
         chk("sel_b", 32'(sel_b), 32'(m_sel(1)));
         chk("joy_b", 32'(ojoy_b), exp_joy(1));
         chk("chg_b", 32'(chg_b), 32'(mchg[1]));
         chk("frm_b", 32'(frm_b), 32'(mfrm[1]));
      end
   end

   // ---------------- driver tasks ----------------
   int chg_cnt;
   int frm_cnt;

   task automatic drive_b(input logic [7:0] v0, input logic [7:0] v1);
      ena_b = 1'b1;
      case (m_sel(1))
         0:       joy_b = v0;
         1:       joy_b = v1;
         default: joy_b = 8'hFF;
      endcase
   endtask

   // Any 12 consecutive enabled cycles of B hold exactly one sample per player.
   task automatic b_cycles(input int cycles, input logic [7:0] v0, input logic [7:0] v1);
      for (int k = 0; k < cycles; k++) begin
         drive_b(v0, v1);
         @(negedge clk);
         if (chg_b) chg_cnt++;
      end
   endtask

   // ---------------- stimulus ----------------
   logic [1:0] exp_seq [13] = '{0,0,0,0,1,1,1,1,2,2,2,2,0};

   initial begin
      int prev_sel, run, prev_c, prev_f;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      // Reset values
      chk("rst_sel_a", 32'(sel_a), 0);
      chk("rst_joy_a", 32'(ojoy_a), 32'h0000_FFFF);
      chk("rst_joy_b", 32'(ojoy_b), 32'h00FF_FFFF);
      chk("rst_pulses", {chg_a, frm_a, chg_b, frm_b}, 0);

      // Legacy 2-player toggle
      chg_cnt = 0; frm_cnt = 0;
      ena_a = 1'b1;
      joy_a = 8'hFE;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (chg_a) chg_cnt++;
         if (frm_a) frm_cnt++;
         if (k == 1) chk("legacy_joy", 32'(ojoy_a), 32'h0000_FDFE);
         joy_a = (m_sel(0) == 0) ? 8'hFE : 8'hFD;
      end
      chk("legacy_chg_count", chg_cnt, 2);
      chk("legacy_frm_count", frm_cnt, 5);
      ena_a = 1'b0;

      // Three-player select sequence with SETTLE=4
      ena_b = 1'b1;
      for (int k = 0; k < 13; k++) begin
         if (k > 0) @(negedge clk);
         chk("seq_sel_b", 32'(sel_b), 32'(exp_seq[k]));
         chk("seq_frm_b", 32'(frm_b), (k == 12) ? 1 : 0);
      end

      // 50% enable: every slot after the first partial one lasts 8 clocks
      prev_sel = sel_b; run = 0; prev_c = 0; prev_f = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         run++;
         if (sel_b != prev_sel) begin
            if (k > 8) chk("half_ena_slot_len", run, 8);
            run = 0;
            prev_sel = sel_b;
         end
         chk("pulse_len_b", {prev_c & chg_b, prev_f & frm_b}, 0);
         prev_c = chg_b; prev_f = frm_b;
         ena_b = ~ena_b;
      end

      // Debounce: two FE samples on player 1 do not commit
      chg_cnt = 0;
      b_cycles(24, 8'hFF, 8'hFE);
      b_cycles(12, 8'hFF, 8'hFF);
      chk("deb_short_p1", 32'(ojoy_b[15:8]), 32'hFF);
      chk("deb_short_chg", chg_cnt, 0);
      // Three FE samples commit with one pulse
      b_cycles(36, 8'hFF, 8'hFE);
      chk("deb_long_p1", 32'(ojoy_b[15:8]), 32'hFE);
      chk("deb_long_chg", chg_cnt, 1);

      // Glitch on player 0: FE, FC, FC, FC commits FC only at the 4th
      chg_cnt = 0;
      b_cycles(12, 8'hFE, 8'hFE);
      chk("glitch_p0_1", 32'(ojoy_b[7:0]), 32'hFF);
      b_cycles(24, 8'hFC, 8'hFE);
      chk("glitch_p0_3", 32'(ojoy_b[7:0]), 32'hFF);
      b_cycles(12, 8'hFC, 8'hFE);
      chk("glitch_p0_4", 32'(ojoy_b[7:0]), 32'hFC);
      chk("glitch_chg", chg_cnt, 1);

      // Overlay on player 0 only
      ena_a = 1'b1; local_a = 8'hBF; joy_a = 8'hFF;
      repeat (4) @(negedge clk);
      chk("overlay_joy_a", 32'(ojoy_a), 32'h0000_FFBF);
      local_a = 8'hFF;

      // Asynchronous reset mid-slot
      b_cycles(5, 8'h00, 8'h11);
      #2 rst_n = 1'b0;
      #1;
      chk("async_sel_b", 32'(sel_b), 0);
      chk("async_joy_b", 32'(ojoy_b), 32'h00FF_FFFF);
      chk("async_joy_a", 32'(ojoy_a), 32'h0000_FFFF);
      chk("async_pulses", {chg_a, frm_a, chg_b, frm_b}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic with one mid-run reset
      for (int k = 0; k < 3000; k++) begin
         ena_a = ($urandom_range(0, 3) != 0);
         ena_b = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) joy_a = 8'($urandom);
         if ($urandom_range(0, 7) == 0) joy_b = 8'($urandom_range(252, 255));
         if ($urandom_range(0, 63) == 0) local_a = 8'($urandom);
         if ($urandom_range(0, 63) == 0) local_b = 8'($urandom_range(250, 255));
         if (k == 1500) begin
            #3 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end
         @(negedge clk);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
